// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and
// exception codes. Imported by cp0_count_timer and cp0_timer_unit.
package cp0_pkg;

   // CP0 register numbers (mfc0/mtc0 addr field)
   localparam logic [4:0] ADDR_BADVADDR = 5'd8;
   localparam logic [4:0] ADDR_COUNT    = 5'd9;
   localparam logic [4:0] ADDR_COMPARE  = 5'd11;
   localparam logic [4:0] ADDR_SR       = 5'd12;
   localparam logic [4:0] ADDR_CAUSE    = 5'd13;
   localparam logic [4:0] ADDR_EPC      = 5'd14;
   localparam logic [4:0] ADDR_PRID     = 5'd15;

   // SR field positions
   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int SR_IM_LO = 10;
   localparam int SR_IM_HI = 15;

   // Cause field positions
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_TI     = 30;
   localparam int CAUSE_BD     = 31;

   // Exception codes
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Address-error exceptions are the only ones that capture BadVAddr.
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// Count/Compare timer for CP0.
//   clk, reset       : clock, asynchronous active-low reset
//   count_we         : load Count from wdata (also restarts the prescaler)
//   compare_we       : load Compare from wdata (also clears TI)
//   wdata            : write data
//   count_rd         : current Count
//   compare_rd       : current Compare
//   ti               : sticky timer-interrupt pending bit
module cp0_count_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count_rd,
   output logic [31:0] compare_rd,
   output logic        ti
);
   import cp0_pkg::*;

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [31:0]   count_q, count_d;
   logic [31:0]   compare_q, compare_d;
   logic          ti_q, ti_d;
   logic          inc_tick;
   logic [31:0]   count_inc;

   assign inc_tick  = (pre_q == PRE_MAX);
   assign count_inc = count_q + 32'd1;

   always_comb begin
      pre_d     = pre_q;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (count_we) begin
         // A Count load restarts the prescaler and masks this cycle's increment/match.
         count_d = wdata;
         pre_d   = '0;
      end else if (inc_tick) begin
         pre_d   = '0;
         count_d = count_inc;
         if (count_inc == compare_q) begin
            ti_d = 1'b1;
         end
      end else begin
         pre_d = pre_q + PW'(1);
      end
      // Compare write acknowledges the timer and overrides a simultaneous match.
      if (compare_we) begin
         compare_d = wdata;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q     <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_rd   = count_q;
   assign compare_rd = compare_q;
   assign ti         = ti_q;

endmodule

// File: rtl/cp0_timer_unit.sv
// Coprocessor 0 with Count/Compare timer and exception/interrupt arbitration.
//   clk, reset      : clock, asynchronous active-low reset
//   we/addr/din     : mtc0 write port; addr also selects the mfc0 read (dout)
//   pc, exc_code_in, bd_in, bad_vaddr_in : committing instruction's exception info
//   hw_int          : level-sensitive external interrupts (IP[NUM_HWINT+9:10])
//   exl_clr         : eret commit, clears EXL
//   req             : take exception/interrupt this cycle
//   epc             : current EPC
//   dout            : mfc0 read data
//   timer_pending   : Cause.TI
module cp0_timer_unit #(
   parameter int          NUM_HWINT = 6,
   parameter int          TIMER_IRQ = 5,
   parameter int          COUNT_DIV = 2,
   parameter logic [31:0] PRID_VAL  = 32'h0000_7001
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [4:0]           addr,
   input  logic [31:0]          din,
   input  logic [31:0]          pc,
   input  logic [4:0]           exc_code_in,
   input  logic                 bd_in,
   input  logic [31:0]          bad_vaddr_in,
   input  logic [NUM_HWINT-1:0] hw_int,
   input  logic                 exl_clr,
   output logic                 req,
   output logic [31:0]          epc,
   output logic [31:0]          dout,
   output logic                 timer_pending
);
   import cp0_pkg::*;

   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] epc_q, epc_d;
   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [4:0]  exc_q, exc_d;
   logic [5:0]  ip_q, ip_d;

   logic [31:0] count_rd, compare_rd;
   logic        ti;
   logic [5:0]  pend;
   logic        int_req, exc_req;
   logic [31:0] sr_rd, cause_rd;

   cp0_count_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (we && (addr == ADDR_COUNT)),
      .compare_we (we && (addr == ADDR_COMPARE)),
      .wdata      (din),
      .count_rd   (count_rd),
      .compare_rd (compare_rd),
      .ti         (ti)
   );

   // Pending vector: HW lines zero-extended to six bits, timer ORed onto its slot.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_pend
         logic hw_bit;
         if (gi < NUM_HWINT) begin : g_hw
            assign hw_bit = hw_int[gi];
         end else begin : g_nohw
            assign hw_bit = 1'b0;
         end
         assign pend[gi] = hw_bit | (ti && (gi == TIMER_IRQ));
      end
   endgenerate

   assign int_req = (|(pend & im_q)) && ie_q && !exl_q;
   assign exc_req = (exc_code_in != EXC_INT) && !exl_q;
   assign req     = int_req || exc_req;

   // Priority: exception/interrupt entry, then mtc0, then eret.
   always_comb begin
      badvaddr_d = badvaddr_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exc_d      = exc_q;
      ip_d       = pend;
      if (req) begin
         exc_d = int_req ? EXC_INT : exc_code_in;
         exl_d = 1'b1;
         bd_d  = bd_in;
         epc_d = bd_in ? (pc - 32'd4) : pc;
         if (!int_req && is_addr_exc(exc_code_in)) begin
            badvaddr_d = bad_vaddr_in;
         end
      end else if (we) begin
         if (addr == ADDR_SR) begin
            im_d  = din[SR_IM_HI:SR_IM_LO];
            exl_d = din[SR_EXL];
            ie_d  = din[SR_IE];
         end
         if (addr == ADDR_EPC) begin
            epc_d = {din[31:2], 2'b00};
         end
      end else if (exl_clr) begin
         exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         badvaddr_q <= '0;
         epc_q      <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         exc_q      <= '0;
         ip_q       <= '0;
      end else begin
         badvaddr_q <= badvaddr_d;
         epc_q      <= epc_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         exc_q      <= exc_d;
         ip_q       <= ip_d;
      end
   end

   always_comb begin
      sr_rd                              = '0;
      sr_rd[SR_IM_HI:SR_IM_LO]           = im_q;
      sr_rd[SR_EXL]                      = exl_q;
      sr_rd[SR_IE]                       = ie_q;
      cause_rd                           = '0;
      cause_rd[CAUSE_BD]                 = bd_q;
      cause_rd[CAUSE_TI]                 = ti;
      cause_rd[CAUSE_IP_HI:CAUSE_IP_LO]  = ip_q;
      cause_rd[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
   end

   always_comb begin
      case (addr)
         ADDR_BADVADDR: dout = badvaddr_q;
         ADDR_COUNT:    dout = count_rd;
         ADDR_COMPARE:  dout = compare_rd;
         ADDR_SR:       dout = sr_rd;
         ADDR_CAUSE:    dout = cause_rd;
         ADDR_EPC:      dout = epc_q;
         ADDR_PRID:     dout = PRID_VAL;
         default:       dout = '0;
      endcase
   end

   assign epc           = epc_q;
   assign timer_pending = ti;

endmodule

// File: tb/tb_cp0_timer_unit.sv
module tb_cp0_timer_unit;
   localparam int          NUM_HWINT = 6;
   localparam int          TIMER_IRQ = 5;
   localparam int          COUNT_DIV = 2;
   localparam logic [31:0] PRID_VAL  = 32'h0000_7001;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 we;
   logic [4:0]           addr;
   logic [31:0]          din;
   logic [31:0]          pc;
   logic [4:0]           exc_code_in;
   logic                 bd_in;
   logic [31:0]          bad_vaddr_in;
   logic [NUM_HWINT-1:0] hw_int;
   logic                 exl_clr;
   logic                 req;
   logic [31:0]          epc;
   logic [31:0]          dout;
   logic                 timer_pending;

   int checks   = 0;
   int failures = 0;

   cp0_timer_unit #(
      .NUM_HWINT (NUM_HWINT),
      .TIMER_IRQ (TIMER_IRQ),
      .COUNT_DIV (COUNT_DIV),
      .PRID_VAL  (PRID_VAL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .we            (we),
      .addr          (addr),
      .din           (din),
      .pc            (pc),
      .exc_code_in   (exc_code_in),
      .bd_in         (bd_in),
      .bad_vaddr_in  (bad_vaddr_in),
      .hw_int        (hw_int),
      .exl_clr       (exl_clr),
      .req           (req),
      .epc           (epc),
      .dout          (dout),
      .timer_pending (timer_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- reference model (register images) ----------------
   bit [31:0] m_count, m_compare, m_epc, m_badv;
   int        m_pre;
   bit        m_ti, m_exl, m_ie, m_bd;
   bit [5:0]  m_im, m_ip;
   bit [4:0]  m_exc;

   function automatic bit [5:0] m_pend();
      bit [5:0] p;
      p = hw_int;
      if (m_ti) p[TIMER_IRQ] = 1'b1;
      return p;
   endfunction

   function automatic bit m_int();
      return ((m_pend() & m_im) != 6'd0) && m_ie && !m_exl;
   endfunction

   function automatic bit m_req();
      return m_int() || ((exc_code_in != 5'd0) && !m_exl);
   endfunction

   function automatic bit [31:0] m_read(input bit [4:0] a);
      case (a)
         5'd8:    return m_badv;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
         5'd13:   return {m_bd, m_ti, 14'h0, m_ip, 3'h0, m_exc, 2'h0};
         5'd14:   return m_epc;
         5'd15:   return PRID_VAL;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_clear();
      m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_pre = 0;
      m_ti = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_im = 0; m_ip = 0; m_exc = 0;
   endtask

   task automatic m_step();
      bit r, ir;
      bit [5:0] p;
      r  = m_req();
      ir = m_int();
      p  = m_pend();
      // timer: one Count step every COUNT_DIV cycles since the last Count load
      if (we && addr == 5'd9) begin
         m_count = din;
         m_pre   = 0;
      end else if (m_pre == COUNT_DIV - 1) begin
         m_pre = 0;
         if (m_count + 32'd1 == m_compare) m_ti = 1'b1;
         m_count = m_count + 32'd1;
      end else begin
         m_pre++;
      end
      if (we && addr == 5'd11) begin
         m_compare = din;
         m_ti      = 1'b0;
      end
      m_ip = p;
      if (r) begin
         m_exc = ir ? 5'd0 : exc_code_in;
         m_exl = 1'b1;
         m_bd  = bd_in;
         m_epc = bd_in ? pc - 32'd4 : pc;
         if (!ir && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) m_badv = bad_vaddr_in;
      end else if (we) begin
         if (addr == 5'd12) begin
            m_im  = din[15:10];
            m_exl = din[1];
            m_ie  = din[0];
         end
         if (addr == 5'd14) m_epc = din & 32'hFFFF_FFFC;
      end else if (exl_clr) begin
         m_exl = 1'b0;
      end
   endtask

   always @(negedge reset) m_clear();
   always @(posedge clk) if (reset) m_step();

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("req",           {31'b0, req},           {31'b0, m_req()});
      chk("epc",           epc,                    m_epc);
      chk("timer_pending", {31'b0, timer_pending}, {31'b0, m_ti});
      chk("dout",          dout,                   m_read(addr));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      we = 0; exc_code_in = 0; exl_clr = 0; bd_in = 0; hw_int = '0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1; addr = a; din = d;
      tick();
   endtask

   initial begin
      reset = 1; we = 0; addr = 0; din = 0; pc = 0; exc_code_in = 0; bd_in = 0;
      bad_vaddr_in = 0; hw_int = '0; exl_clr = 0;
      #1 reset = 0;
      addr = 5'd15;
      #2;
      chk("rst_prid", dout, PRID_VAL);
      chk("rst_req", {31'b0, req}, 32'd0);
      tick(); tick();
      reset = 1;
      tick();

      // T2: interrupt entry and EXL masking
      wr(5'd12, 32'h0000_0401);
      addr = 5'd12; @(negedge clk); chk("t2_sr", dout, 32'h0000_0401); tick();
      hw_int = 6'd1; pc = 32'h1000; @(negedge clk); chk("t2_req", {31'b0, req}, 32'd1); tick();
      hw_int = 6'd1; addr = 5'd13; @(negedge clk);
      chk("t2_req_masked", {31'b0, req}, 32'd0); chk("t2_cause", dout, 32'h0000_0400); tick();
      hw_int = 6'd1; addr = 5'd12; @(negedge clk);
      chk("t2_sr_exl", dout, 32'h0000_0403); chk("t2_epc", epc, 32'h1000); tick();
      hw_int = 6'd1; exl_clr = 1; @(negedge clk); chk("t2_req_eret", {31'b0, req}, 32'd0); tick();
      hw_int = 6'd1; pc = 32'h1100; @(negedge clk); chk("t2_req_again", {31'b0, req}, 32'd1); tick();
      exl_clr = 1; tick();

      // T3: AdEL in a delay slot, same-cycle EPC write dropped
      exc_code_in = 5'd4; bd_in = 1; pc = 32'h3008; bad_vaddr_in = 32'h1003;
      we = 1; addr = 5'd14; din = 32'hDEAD_BEE0;
      @(negedge clk); chk("t3_req", {31'b0, req}, 32'd1); tick();
      addr = 5'd14; @(negedge clk); chk("t3_epc", dout, 32'h3004); tick();
      addr = 5'd13; @(negedge clk); chk("t3_cause", dout, 32'h8000_0010); tick();
      addr = 5'd8;  @(negedge clk); chk("t3_badv", dout, 32'h1003); exl_clr = 1; tick();

      // T6: interrupt beats exception; EPC alignment; unmapped read
      hw_int = 6'd1; exc_code_in = 5'd12; pc = 32'h2000;
      @(negedge clk); chk("t6_req", {31'b0, req}, 32'd1); tick();
      addr = 5'd13; exl_clr = 1; @(negedge clk); chk("t6_cause", dout, 32'h0000_0400); tick();
      wr(5'd14, 32'h3007);
      addr = 5'd14; @(negedge clk); chk("t6_epc_align", dout, 32'h3004); tick();
      addr = 5'd20; @(negedge clk); chk("t6_unmapped", dout, 32'h0); tick();
      addr = 5'd8;  @(negedge clk); chk("t6_badv_kept", dout, 32'h1003); tick();

      // T4: Compare=10 match after the 10th increment
      wr(5'd12, 32'h0000_8001);
      wr(5'd9, 32'h0);
      wr(5'd11, 32'd10);
      wr(5'd9, 32'h0);
      addr = 5'd9;
      for (int i = 1; i < 20; i++) tick();
      @(negedge clk);
      chk("t4_tp_before", {31'b0, timer_pending}, 32'd0); chk("t4_count9", dout, 32'd9);
      tick();
      @(negedge clk);
      chk("t4_tp_set", {31'b0, timer_pending}, 32'd1); chk("t4_req", {31'b0, req}, 32'd1);
      chk("t4_count10", dout, 32'd10);
      tick();
      addr = 5'd13; @(negedge clk); chk("t4_cause", dout, 32'h4000_8000); tick();
      wr(5'd11, 32'h100);
      addr = 5'd11; @(negedge clk);
      chk("t4_tp_clr", {31'b0, timer_pending}, 32'd0); chk("t4_compare", dout, 32'h100); tick();

      // T5: wrap-around match, then Compare write in the match cycle
      wr(5'd11, 32'h0);
      wr(5'd9, 32'hFFFF_FFFF);
      addr = 5'd9; tick();
      @(negedge clk);
      chk("t5_count_max", dout, 32'hFFFF_FFFF); chk("t5_tp0", {31'b0, timer_pending}, 32'd0);
      tick();
      @(negedge clk);
      chk("t5_count_wrap", dout, 32'h0); chk("t5_tp1", {31'b0, timer_pending}, 32'd1);
      wr(5'd11, 32'h0);
      wr(5'd9, 32'hFFFF_FFFF);
      tick();
      wr(5'd11, 32'h0);
      addr = 5'd9; @(negedge clk);
      chk("t5_count_wrap2", dout, 32'h0); chk("t5_tp_suppr", {31'b0, timer_pending}, 32'd0);
      tick();

      // T1: asynchronous reset mid-run
      wr(5'd9, 32'h20);
      addr = 5'd12; #1; chk("t1_sr_pre", dout, 32'h0000_8003);
      addr = 5'd9;  #1; chk("t1_count_pre", dout, 32'h20);
      reset = 0; #1;
      chk("t1_count", dout, 32'h0); chk("t1_epc", epc, 32'h0);
      chk("t1_req", {31'b0, req}, 32'd0); chk("t1_tp", {31'b0, timer_pending}, 32'd0);
      addr = 5'd15; #1; chk("t1_prid", dout, PRID_VAL);
      addr = 5'd12; #1; chk("t1_sr", dout, 32'h0);
      tick(); tick();
      reset = 1;
      tick(); tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
